apb_slave_array: RTL and testbench

- Parametrised APB completer array on the APB side of the AHB-APB bridge.
- Supersedes the single pass-through completer and its random read data.
- Provides NUM_SLAVES independent register banks, each DEPTH words deep, selected by a one-hot Pselx.
- Adds wait-state insertion through Pready, error signalling through Pslverr, and deterministic read data from stored registers.

---
 rtl/apb_slave_array.sv | 144 ++++++++++++++
 tb/tb_apb_slave_array.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_array.sv
// APB completer array: NUM_SLAVES independent register banks of DEPTH words,
// selected by a one-hot Pselx. Wait states are inserted before Pready, and
// malformed accesses are answered with Pslverr.
//
// Handshake: a transfer starts with a setup cycle (Pselx != 0, Penable = 0)
// while the FSM is IDLE. Pready is high for exactly one cycle. Prdata and
// Pslverr are meaningful only in that cycle. In WAIT, dropping Penable or
// changing Pselx abandons the transfer without a response. A write commits on
// the Pready cycle only if Penable is high, Pselx is unchanged and no error
// was flagged.
module apb_slave_array #(
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_W-1:0]     Paddr,
  input  logic [DATA_W-1:0]     Pwdata,
  output logic [DATA_W-1:0]     Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [1:0]            dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        wait_cnt;
  logic [NUM_SLAVES-1:0]   lat_sel;
  logic [SEL_W-1:0]        lat_idx;
  logic                    lat_write;
  logic [DATA_W-1:0]       lat_wdata;
  logic [AW-1:0]           lat_word;
  logic                    lat_err;
  logic [DATA_W-1:0]       bank [NUM_SLAVES][DEPTH];

  logic                    setup;
  logic                    sel_onehot;
  logic                    addr_err;
  logic                    req_err;
  logic [SEL_W-1:0]        sel_idx;
  logic [AW-1:0]           word_idx;

  assign dbg_state = state;

  // Decode the live bus: setup detection, bank index and error conditions.
  always_comb begin
    setup      = (Pselx != '0) && !Penable;
    sel_onehot = (Pselx != '0) && ((Pselx & (Pselx - NUM_SLAVES'(1))) == '0);
    addr_err   = (Paddr[1:0] != 2'b00) || ((Paddr >> (AW + 2)) != '0);
    req_err    = !sel_onehot || addr_err;
    word_idx   = Paddr[AW+1:2];
    // Lowest set bit wins; only relevant for the one-hot (error-free) case.
    sel_idx    = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (Pselx[i]) sel_idx = SEL_W'(i);
    end
  end

  // Transfer FSM, registered response outputs and bank storage.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_sel   <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_word  <= '0;
      lat_err   <= 1'b0;
      Prdata    <= '0;
      Pready    <= 1'b0;
      Pslverr   <= 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          bank[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          Pready <= 1'b0;
          if (setup) begin
            lat_sel   <= Pselx;
            lat_idx   <= sel_idx;
            lat_write <= Pwrite;
            lat_wdata <= Pwdata;
            lat_word  <= word_idx;
            lat_err   <= req_err;
            if (WAIT_STATES == 0) begin
              // Response loads straight from the live bus on entry to DONE.
              state   <= DONE;
              Pready  <= 1'b1;
              Pslverr <= req_err;
              Prdata  <= (!Pwrite && !req_err) ? bank[sel_idx][word_idx] : '0;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_W'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!Penable || (Pselx != lat_sel)) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            if (wait_cnt == CNT_W'(1)) begin
              state   <= DONE;
              Pready  <= 1'b1;
              Pslverr <= lat_err;
              Prdata  <= (!lat_write && !lat_err) ? bank[lat_idx][lat_word] : '0;
            end
          end
        end
        DONE: begin
          if (lat_write && !lat_err && Penable && (Pselx == lat_sel)) begin
            bank[lat_idx][lat_word] <= lat_wdata;
          end
          Pready <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          Pready <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_array.sv
// Bench for apb_slave_array: three instances with WAIT_STATES of 0, 3 and 2
// share one clock; each has its own bus and reset. A bank model predicts read
// data and error responses, queued when a transfer is driven and compared
// when Pready appears.
module tb_apb_slave_array;

  logic        clk;
  logic        rst_n   [3];
  logic [2:0]  psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  wire  [31:0] prdata  [3];
  wire         pready  [3];
  wire         pslverr [3];
  wire  [1:0]  dbg     [3];

  logic [31:0] model [3][3][16];
  logic [32:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;

  // Clock and instances
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_array #(
      .NUM_SLAVES (3),
      .DEPTH      (16),
      .DATA_W     (32),
      .ADDR_W     (32),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .Hclk     (clk),
      .Hresetn  (rst_n[g]),
      .Pselx    (psel[g]),
      .Penable  (penable[g]),
      .Pwrite   (pwrite[g]),
      .Paddr    (paddr[g]),
      .Pwdata   (pwdata[g]),
      .Prdata   (prdata[g]),
      .Pready   (pready[g]),
      .Pslverr  (pslverr[g]),
      .dbg_state(dbg[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_idle(input int d);
    @(posedge clk); #1;
    psel[d] = 3'b000; penable[d] = 1'b0; pwrite[d] = 1'b0;
    @(negedge clk);
    check_val("idle_pready", 32'(pready[d]), 32'd0);
  endtask

  // One complete transfer; leaves the bus in the access phase so the next
  // call can start a back-to-back setup.
  task automatic apb_xfer(input int d, input bit wr, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    int          idx;
    int          w;
    int          waits;
    logic [31:0] exp_rd;
    logic [32:0] e;
    err    = !(sel == 3'b001 || sel == 3'b010 || sel == 3'b100) ||
             (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0);
    idx    = (sel == 3'b001) ? 0 : (sel == 3'b010) ? 1 : 2;
    w      = int'(addr[5:2]);
    exp_rd = (!wr && !err) ? model[d][idx][w] : 32'd0;
    exp_q.push_back({err, exp_rd});
    @(posedge clk); #1;
    psel[d] = sel; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata;
    @(negedge clk);
    check_val("setup_pready", 32'(pready[d]), 32'd0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!pready[d] && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check_val("wait_cycles", 32'(waits), 32'(ws_of(d)));
    check_val("pready", 32'(pready[d]), 32'd1);
    e = exp_q.pop_front();
    check_val("prdata", prdata[d], e[31:0]);
    check_val("pslverr", 32'(pslverr[d]), 32'(e[32]));
    if (wr && !err) model[d][idx][w] = wdata;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; psel[d] = '0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
      for (int s = 0; s < 3; s++)
        for (int w = 0; w < 16; w++) model[d][s][w] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_val("rst_pready", 32'(pready[d]), 32'd0);
      check_val("rst_pslverr", 32'(pslverr[d]), 32'd0);
      check_val("rst_prdata", prdata[d], 32'd0);
      check_val("rst_state", 32'(dbg[d]), 32'd0);
      rst_n[d] = 1'b1;
    end

    // Basic write/read, zero wait states
    apb_xfer(0, 1, 3'b001, 32'h08, 32'hDEADBEEF);
    apb_xfer(0, 0, 3'b001, 32'h08, 32'h0);
    bus_idle(0);

    // Bank isolation
    apb_xfer(0, 1, 3'b010, 32'h04, 32'h11);
    apb_xfer(0, 0, 3'b100, 32'h04, 32'h0);
    apb_xfer(0, 0, 3'b010, 32'h04, 32'h0);

    // Random traffic across banks and words, back to back
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  s;
      logic [31:0] a;
      s = 3'b001 << $urandom_range(0, 2);
      a = 32'($urandom_range(0, 15)) << 2;
      apb_xfer(0, 1'($urandom_range(0, 1)), s, a, $urandom);
    end
    bus_idle(0);

    // Errors: word 0 of each bank first gets a known value
    apb_xfer(0, 1, 3'b001, 32'h00, 32'hAAAA0001);
    apb_xfer(0, 1, 3'b010, 32'h00, 32'hAAAA0002);
    apb_xfer(0, 1, 3'b100, 32'h00, 32'hAAAA0004);
    apb_xfer(0, 1, 3'b001, 32'h40, 32'hBAD00040);
    apb_xfer(0, 1, 3'b001, 32'h06, 32'hBAD00006);
    apb_xfer(0, 1, 3'b011, 32'h00, 32'hBAD00011);
    apb_xfer(0, 0, 3'b001, 32'h40, 32'h0);
    apb_xfer(0, 0, 3'b001, 32'h00, 32'h0);
    apb_xfer(0, 0, 3'b001, 32'h04, 32'h0);
    apb_xfer(0, 0, 3'b010, 32'h00, 32'h0);
    apb_xfer(0, 0, 3'b100, 32'h00, 32'h0);
    bus_idle(0);

    // Penable high without a setup phase is ignored
    @(posedge clk); #1;
    psel[0] = 3'b001; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h0; pwdata[0] = 32'hFFFFFFFF;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (pready[0]) hi++;
    end
    check_val("no_setup_pready", 32'(hi), 32'd0);
    bus_idle(0);
    apb_xfer(0, 0, 3'b001, 32'h00, 32'h0);
    bus_idle(0);

    // Three wait states
    apb_xfer(1, 1, 3'b001, 32'h0C, 32'h0000C0DE);
    apb_xfer(1, 0, 3'b001, 32'h0C, 32'h0);
    bus_idle(1);

    // Abort during WAIT with two wait states
    apb_xfer(2, 1, 3'b001, 32'h00, 32'h0000005A);
    bus_idle(2);
    @(posedge clk); #1;
    psel[2] = 3'b001; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h0; pwdata[2] = 32'h000000A5;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    penable[2] = 1'b0;
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready[2]) hi++;
    end
    check_val("abort_pready", 32'(hi), 32'd0);
    check_val("abort_state", 32'(dbg[2]), 32'd0);
    bus_idle(2);
    apb_xfer(2, 0, 3'b001, 32'h00, 32'h0);
    bus_idle(2);

    // Reset in the middle of a WAIT
    apb_xfer(1, 1, 3'b010, 32'h0C, 32'h00001234);
    apb_xfer(1, 0, 3'b010, 32'h0C, 32'h0);
    @(posedge clk); #1;
    psel[1] = 3'b010; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h0C;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    check_val("midrst_pready", 32'(pready[1]), 32'd0);
    check_val("midrst_prdata", prdata[1], 32'd0);
    check_val("midrst_state", 32'(dbg[1]), 32'd0);
    psel[1] = 3'b000; penable[1] = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++) model[1][s][w] = 32'd0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    apb_xfer(1, 0, 3'b001, 32'h0C, 32'h0);
    apb_xfer(1, 0, 3'b010, 32'h0C, 32'h0);
    apb_xfer(1, 0, 3'b100, 32'h00, 32'h0);

    // Back-to-back writes, both must commit
    apb_xfer(1, 1, 3'b001, 32'h14, 32'h55550005);
    apb_xfer(1, 1, 3'b100, 32'h18, 32'h66660006);
    apb_xfer(1, 0, 3'b001, 32'h14, 32'h0);
    apb_xfer(1, 0, 3'b100, 32'h18, 32'h0);
    bus_idle(1);
    apb_xfer(0, 1, 3'b001, 32'h14, 32'h77770005);
    apb_xfer(0, 1, 3'b100, 32'h18, 32'h88880006);
    apb_xfer(0, 0, 3'b001, 32'h14, 32'h0);
    apb_xfer(0, 0, 3'b100, 32'h18, 32'h0);
    bus_idle(0);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
